// File: rtl/psum_accumulator.sv
// psum_accumulator: sums signed beats into groups delimited by first/last markers over valid/ready.
// Define ACC_SATURATE_EN for per-add saturation with a sticky out_sat flag; default wraps.
module psum_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state, state_next;
    logic [ACC_WIDTH-1:0] acc, acc_next, ext, base, sum, result;
    logic accept, fresh, take;
    assign in_ready = !out_valid || out_ready;
    assign accept = in_valid && in_ready;
    assign take = accept && in_last;
    assign ext = ACC_WIDTH'($signed(in_data));
`ifdef ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    logic ovf, sat, sat_next, grp_sat, sat_q;
    assign out_sat = sat_q;
`else
    assign out_sat = 1'b0;
`endif
    always_comb begin
        fresh = in_first || state == IDLE;
        base = fresh ? '0 : acc;
        sum = base + ext;
`ifdef ACC_SATURATE_EN
        // overflow only when operands agree in sign and the sum does not
        ovf = base[ACC_WIDTH-1] == ext[ACC_WIDTH-1] && sum[ACC_WIDTH-1] != base[ACC_WIDTH-1];
        result = ovf ? (base[ACC_WIDTH-1] ? ~MAX : MAX) : sum;
        grp_sat = (!fresh && sat) || ovf;
        sat_next = accept ? (!in_last && grp_sat) : sat;
`else
        result = sum;
`endif
        state_next = state;
        acc_next = acc;
        if (accept) begin
            state_next = in_last ? IDLE : ACCUM;
            acc_next = in_last ? '0 : result;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            acc <= acc_next;
            if (take) begin
                out_data <= result;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
`ifdef ACC_SATURATE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sat <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            sat <= sat_next;
            if (take) sat_q <= grp_sat;
        end
    end
`endif
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed and randomized checks against an integer group-sum model.
module tb_psum_accumulator;
    localparam int IW = 8;
    localparam int AW = 12;
    logic clk = 1'b0;
    logic reset;
    logic [IW-1:0] in_data;
    logic in_valid, in_first, in_last, in_ready;
    logic [AW-1:0] out_data;
    logic out_sat, out_valid, out_ready;
    int checks = 0;
    int failures = 0;
    // model state: open group, running sum, sticky sat, and the held output
    bit m_open, m_sat, m_ov, m_os;
    int m_sum, m_od;

    psum_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int wrap12(int s);
        int r = s & 32'hFFF;
        return r >= 2048 ? r - 4096 : r;
    endfunction

    task automatic model_clear();
        m_open = 0; m_sat = 0; m_sum = 0; m_ov = 0; m_od = 0; m_os = 0;
    endtask

    task automatic model_step(input bit v, f, l, input int d, input bit ordy);
        bit acc, fresh, s_sat;
        int s;
        acc = v && (!m_ov || ordy);
        fresh = f || !m_open;
        s = (fresh ? 0 : m_sum) + d;
        s_sat = fresh ? 0 : m_sat;
`ifdef ACC_SATURATE_EN
        if (s > 2047) begin s = 2047; s_sat = 1; end
        else if (s < -2048) begin s = -2048; s_sat = 1; end
`else
        s = wrap12(s);
        s_sat = 0;
`endif
        if (acc && l) begin m_ov = 1; m_od = s; m_os = s_sat; end
        else if (ordy) m_ov = 0;
        if (acc) begin
            m_open = !l;
            m_sum = l ? 0 : s;
            m_sat = l ? 0 : s_sat;
        end
    endtask

    // drives one beat, reports in_ready seen before the edge, returns #1 after the edge
    task automatic cycle(input bit v, f, l, input int d, input bit ordy, output logic rdy);
        in_valid = v; in_first = f; in_last = l; in_data = IW'(d); out_ready = ordy;
        #1;
        rdy = in_ready;
        model_step(v, f, l, d, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; in_first = 0; in_last = 0; in_data = '0; out_ready = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_clear();
    endtask

    task automatic test_reset();
        logic r;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 12'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", out_data); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", out_sat); end
        cycle(0, 0, 0, 0, 0, r);
        checks++; if (r !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", r); end
    endtask

    task automatic test_basic();
        logic r;
        int beats[3] = '{5, -3, 10};
        for (int i = 0; i < 3; i++) begin
            cycle(1, i == 0, i == 2, beats[i], 1, r);
            checks++; if (r !== 1'b1) begin failures++; $display("FAIL basic_ready beat=%0d got=%b exp=1", i, r); end
            if (i < 2) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid beat=%0d got=%b exp=0", i, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 12'd12) begin failures++; $display("FAIL basic_sum got=%b/%0d exp=1/12", out_valid, $signed(out_data)); end
        cycle(0, 0, 0, 0, 1, r);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic r;
        int vals[4] = '{-7, 127, -128, 0};
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 1, vals[i], 1, r);
            checks++; if (out_valid !== 1'b1 || out_data !== 12'(vals[i])) begin failures++; $display("FAIL b2b_%0d got=%b/%0d exp=1/%0d", i, out_valid, $signed(out_data), vals[i]); end
        end
        cycle(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_backpressure();
        logic r;
        cycle(1, 1, 0, 1, 0, r);
        cycle(1, 0, 1, 2, 0, r);
        checks++; if (out_valid !== 1'b1 || out_data !== 12'd3) begin failures++; $display("FAIL bp_first got=%b/%0d exp=1/3", out_valid, $signed(out_data)); end
        cycle(1, 1, 1, 4, 0, r);
        checks++; if (r !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", r); end
        checks++; if (out_valid !== 1'b1 || out_data !== 12'd3) begin failures++; $display("FAIL bp_hold got=%b/%0d exp=1/3", out_valid, $signed(out_data)); end
        cycle(1, 1, 1, 4, 1, r);
        checks++; if (r !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", r); end
        checks++; if (out_valid !== 1'b1 || out_data !== 12'd4) begin failures++; $display("FAIL bp_next got=%b/%0d exp=1/4", out_valid, $signed(out_data)); end
        cycle(0, 0, 0, 0, 1, r);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        logic r;
`ifdef ACC_SATURATE_EN
        int exp_d = 2047; logic exp_s = 1'b1;
`else
        int exp_d = -1937; logic exp_s = 1'b0;
`endif
        for (int i = 0; i < 17; i++) cycle(1, i == 0, i == 16, 127, 1, r);
        checks++; if (out_valid !== 1'b1 || out_data !== 12'(exp_d)) begin failures++; $display("FAIL ovf_data got=%b/%0d exp=1/%0d", out_valid, $signed(out_data), exp_d); end
        checks++; if (out_sat !== exp_s) begin failures++; $display("FAIL ovf_sat got=%b exp=%b", out_sat, exp_s); end
        cycle(1, 1, 1, 1, 1, r);
        checks++; if (out_data !== 12'd1 || out_sat !== 1'b0) begin failures++; $display("FAIL ovf_after got=%0d/%b exp=1/0", $signed(out_data), out_sat); end
        cycle(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_restart();
        logic r;
        cycle(1, 1, 0, 9, 1, r);
        cycle(1, 1, 0, 4, 1, r);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL restart_valid got=%b exp=0", out_valid); end
        cycle(1, 0, 1, 6, 1, r);
        checks++; if (out_valid !== 1'b1 || out_data !== 12'd10) begin failures++; $display("FAIL restart_sum got=%b/%0d exp=1/10", out_valid, $signed(out_data)); end
        cycle(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_mid_reset();
        logic r;
        cycle(1, 1, 0, 50, 1, r);
        cycle(1, 0, 0, 60, 1, r);
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_during got=%b exp=0", out_valid); end
        cycle(0, 0, 0, 0, 1, r);
        checks++; if (out_valid !== 1'b0 || r !== 1'b1) begin failures++; $display("FAIL midrst_after got=%b/%b exp=0/1", out_valid, r); end
        cycle(1, 1, 1, 2, 1, r);
        checks++; if (out_valid !== 1'b1 || out_data !== 12'd2) begin failures++; $display("FAIL midrst_sum got=%b/%0d exp=1/2", out_valid, $signed(out_data)); end
        cycle(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_random();
        logic r;
        bit v, f, l, o, exp_r;
        int d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = $urandom_range(3) != 0;
            f = $urandom_range(3) == 0;
            l = $urandom_range(9) < 3;
            o = $urandom_range(9) < 7;
            d = int'($urandom_range(255)) - 128;
            exp_r = !m_ov || o;
            cycle(v, f, l, d, o, r);
            checks++; if (r !== exp_r) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, r, exp_r); end
            checks++; if (out_valid !== m_ov) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (out_data !== 12'(m_od) || out_sat !== m_os) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0d/%b exp=%0d/%b", i, $signed(out_data), out_sat, m_od, m_os); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_restart();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
